// File: rtl/clock_crossing_hold_reg.sv
// -----------------------------------------------------------------------------
// clock_crossing_hold_reg
//
// Source-side half of a 4-phase (level) req/ack clock-domain crossing.
// A word accepted on the valid/ready enqueue port is captured into a hold
// register and presented on io_cross_data. While it is held there, a level
// request is raised towards the destination domain. The destination's level
// acknowledge is brought into this domain through a SYNC_STAGES-deep
// synchroniser before the FSM looks at it. After the acknowledge rises and
// falls again, the block returns to idle and can accept the next word.
//
// Ports
//   clock          in   1        sole clock, all flops on posedge
//   reset          in   1        synchronous, active-high
//   io_enq_valid   in   1        word offered on io_enq_bits
//   io_enq_ready   out  1        block can accept a word this cycle
//   io_enq_bits    in   WIDTH    word to transfer
//   io_cross_data  out  WIDTH    held word, registered, to destination domain
//   io_cross_req   out  1        registered level request to destination
//   io_cross_ack   in   1        asynchronous level ack from destination
//   io_busy        out  1        handshake in progress (not idle)
//   io_count       out  COUNT_W  completed transfers, wraps silently
// -----------------------------------------------------------------------------
module clock_crossing_hold_reg #(
  parameter int unsigned      WIDTH       = 15,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
  parameter int unsigned      COUNT_W     = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               io_enq_valid,
  output logic               io_enq_ready,
  input  logic [WIDTH-1:0]   io_enq_bits,
  output logic [WIDTH-1:0]   io_cross_data,
  output logic               io_cross_req,
  input  logic               io_cross_ack,
  output logic               io_busy,
  output logic [COUNT_W-1:0] io_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_REL  = 2'd2
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [WIDTH-1:0]       r_data;
  logic                   r_req;
  logic                   r_busy;
  logic [COUNT_W-1:0]     r_count;

  logic w_ack_s;
  logic w_enq_ready;
  logic w_fire;

  // Only the last synchroniser flop is trusted; the raw ack never reaches logic.
  assign w_ack_s = r_sync[SYNC_STAGES-1];

  // Synchroniser chain for the asynchronous destination acknowledge.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync <= {SYNC_STAGES{1'b0}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], io_cross_ack};
    end
  end

  // Ready only when idle and the previous ack has been seen low, so a stale
  // ack left over from before a reset can never overlap a fresh request.
  always_comb begin
    w_enq_ready = 1'b0;
    if (r_state == ST_IDLE) begin
      w_enq_ready = ~w_ack_s;
    end else begin
      w_enq_ready = 1'b0;
    end
  end

  assign w_fire = io_enq_valid & w_enq_ready;

  // Handshake FSM with registered req/busy decode, hold register and counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_req   <= 1'b0;
      r_busy  <= 1'b0;
      r_data  <= RESET_VALUE;
      r_count <= {COUNT_W{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          // The hold register is written on this edge only, so the word is
          // already stable when req rises on the same edge.
          if (w_fire) begin
            r_data  <= io_enq_bits;
            r_state <= ST_REQ;
            r_req   <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        ST_REQ: begin
          // Destination has taken the word: drop req and count the transfer.
          if (w_ack_s) begin
            r_state <= ST_REL;
            r_req   <= 1'b0;
            r_count <= r_count + COUNT_W'(1'b1);
          end
        end
        ST_REL: begin
          // Wait for the ack to be released before accepting another word.
          if (!w_ack_s) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_req   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign io_enq_ready  = w_enq_ready;
  assign io_cross_data = r_data;
  assign io_cross_req  = r_req;
  assign io_busy       = r_busy;
  assign io_count      = r_count;

endmodule

// File: tb/tb_clock_crossing_hold_reg.sv
// -----------------------------------------------------------------------------
// tb_clock_crossing_hold_reg
//
// Instance A: WIDTH=15, SYNC_STAGES=2, COUNT_W=8, destination model that
//   loops req back as ack after a programmable delay, with an override.
// Instance B: WIDTH=1,  SYNC_STAGES=3, COUNT_W=2, zero-delay loopback.
// Instance C: WIDTH=64, SYNC_STAGES=3, COUNT_W=8, zero-delay loopback.
// A transaction-level model of instance A is checked every cycle; directed
// literal expectations pin the timing and values.
// -----------------------------------------------------------------------------
module tb_clock_crossing_hold_reg;

  logic clk = 1'b0;
  logic rst;

  logic        a_valid, a_ready, a_req, a_ack, a_busy;
  logic [14:0] a_bits, a_data;
  logic [7:0]  a_count;

  logic        b_valid, b_ready, b_req, b_busy;
  logic [0:0]  b_bits, b_data;
  logic [1:0]  b_count;

  logic        c_valid, c_ready, c_req, c_busy;
  logic [63:0] c_bits, c_data;
  logic [7:0]  c_count;

  // destination model for instance A
  logic        ovr_en, ovr_val;
  int          dly;
  logic [15:0] req_hist = 16'h0000;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk) req_hist <= {req_hist[14:0], a_req};

  assign a_ack = ovr_en ? ovr_val : ((dly == 0) ? a_req : req_hist[dly-1]);

  clock_crossing_hold_reg #(.WIDTH(15), .SYNC_STAGES(2), .RESET_VALUE(15'h0000), .COUNT_W(8)) u_a (
    .clock(clk), .reset(rst), .io_enq_valid(a_valid), .io_enq_ready(a_ready),
    .io_enq_bits(a_bits), .io_cross_data(a_data), .io_cross_req(a_req),
    .io_cross_ack(a_ack), .io_busy(a_busy), .io_count(a_count));

  clock_crossing_hold_reg #(.WIDTH(1), .SYNC_STAGES(3), .RESET_VALUE(1'b0), .COUNT_W(2)) u_b (
    .clock(clk), .reset(rst), .io_enq_valid(b_valid), .io_enq_ready(b_ready),
    .io_enq_bits(b_bits), .io_cross_data(b_data), .io_cross_req(b_req),
    .io_cross_ack(b_req), .io_busy(b_busy), .io_count(b_count));

  clock_crossing_hold_reg #(.WIDTH(64), .SYNC_STAGES(3), .RESET_VALUE(64'h0), .COUNT_W(8)) u_c (
    .clock(clk), .reset(rst), .io_enq_valid(c_valid), .io_enq_ready(c_ready),
    .io_enq_bits(c_bits), .io_cross_data(c_data), .io_cross_req(c_req),
    .io_cross_ack(c_req), .io_busy(c_busy), .io_count(c_count));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- transaction model of instance A ----------------
  // A word is held from acceptance until the destination has seen it and let
  // go; the destination's ack reaches the block 2 cycles late (zero after reset).
  logic        m_on = 1'b0;
  logic        m_wait_hi, m_wait_lo, m_exp_ready, m_ack_seen;
  logic [14:0] m_data;
  logic [7:0]  m_count;
  logic [1:0]  m_ack_delay;
  logic        prev_req = 1'b0;
  int          req_pulses = 0;

  initial forever begin
    @(negedge clk);
    if (m_on) begin
      m_exp_ready = !m_wait_hi && !m_wait_lo && !m_ack_delay[1];
      chk("model_ready", {63'd0, a_ready}, {63'd0, m_exp_ready});
      chk("model_req",   {63'd0, a_req},   {63'd0, m_wait_hi});
      chk("model_busy",  {63'd0, a_busy},  {63'd0, (m_wait_hi | m_wait_lo)});
      chk("model_data",  {49'd0, a_data},  {49'd0, m_data});
      chk("model_count", {56'd0, a_count}, {56'd0, m_count});
    end
    if (a_req && !prev_req) req_pulses++;
    prev_req = a_req;
    if (rst) begin
      m_on = 1'b1; m_wait_hi = 1'b0; m_wait_lo = 1'b0;
      m_data = 15'h0000; m_count = 8'd0; m_ack_delay = 2'b00;
    end else if (m_on) begin
      m_ack_seen = m_ack_delay[1];
      if (!m_wait_hi && !m_wait_lo && !m_ack_seen && a_valid) begin
        m_data = a_bits; m_wait_hi = 1'b1;
      end else if (m_wait_hi && m_ack_seen) begin
        m_wait_hi = 1'b0; m_wait_lo = 1'b1; m_count = m_count + 8'd1;
      end else if (m_wait_lo && !m_ack_seen) begin
        m_wait_lo = 1'b0;
      end
      m_ack_delay = {m_ack_delay[0], a_ack};
    end
  end

  // cycles (counted from the next negedge as 1) until instance A is ready
  task automatic rt_a(output int n);
    n = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (a_ready) begin n = i; break; end
    end
  endtask

  task automatic xfer_bc(input logic bb, input logic [63:0] cw, input logic [1:0] exp_cnt, input string tag);
    int nb, nc;
    b_valid = 1'b1; c_valid = 1'b1; b_bits = bb; c_bits = cw;
    @(negedge clk);
    chk({tag, "_b_ready"}, {63'd0, b_ready}, 64'd1);
    chk({tag, "_c_ready"}, {63'd0, c_ready}, 64'd1);
    step();
    b_valid = 1'b0; c_valid = 1'b0;
    nb = 0; nc = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) begin
        chk({tag, "_b_data"}, {63'd0, b_data}, {63'd0, bb});
        chk({tag, "_c_data"}, c_data, cw);
        chk({tag, "_c_req"}, {63'd0, c_req}, 64'd1);
      end
      if (b_ready && nb == 0) nb = i;
      if (c_ready && nc == 0) nc = i;
      if (nb != 0 && nc != 0) break;
    end
    chk({tag, "_b_roundtrip"}, 64'(nb), 64'd9);
    chk({tag, "_c_roundtrip"}, 64'(nc), 64'd9);
    chk({tag, "_b_count"}, {62'd0, b_count}, {62'd0, exp_cnt});
    chk({tag, "_c_data_held"}, c_data, cw);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nh, pulses0;
    logic ok;
    rst = 1'b1; a_valid = 1'b0; a_bits = 15'h0; b_valid = 1'b0; b_bits = 1'b0;
    c_valid = 1'b0; c_bits = 64'h0; ovr_en = 1'b0; ovr_val = 1'b0; dly = 0;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_a_req",   {63'd0, a_req},   64'd0);
    chk("rst_a_data",  {49'd0, a_data},  64'd0);
    chk("rst_a_count", {56'd0, a_count}, 64'd0);
    chk("rst_a_busy",  {63'd0, a_busy},  64'd0);
    chk("rst_a_ready", {63'd0, a_ready}, 64'd1);
    chk("rst_c_data",  c_data, 64'd0);
    step();

    // 1: single word with zero-delay loopback
    a_valid = 1'b1; a_bits = 15'h1234;
    @(negedge clk);
    chk("t1_ready_at_fire", {63'd0, a_ready}, 64'd1);
    step();
    a_valid = 1'b0;
    @(negedge clk);
    chk("t1_req_next", {63'd0, a_req}, 64'd1);
    chk("t1_data", {49'd0, a_data}, 64'h1234);
    rt_a(n);
    chk("t1_roundtrip", 64'(n + 1), 64'd7);
    chk("t1_count", {56'd0, a_count}, 64'd1);
    chk("t1_data_kept", {49'd0, a_data}, 64'h1234);
    step();

    // 2: valid held high, back-to-back words
    pulses0 = req_pulses;
    for (int w = 1; w <= 4; w++) begin
      a_valid = 1'b1; a_bits = 15'(w);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (a_ready) begin ok = 1'b1; break; end
      end
      chk("t2_fire_seen", {63'd0, ok}, 64'd1);
      step();
    end
    a_valid = 1'b0;
    rt_a(n);
    chk("t2_req_pulses", 64'(req_pulses - pulses0), 64'd4);
    chk("t2_count", {56'd0, a_count}, 64'd5);
    chk("t2_data", {49'd0, a_data}, 64'h0004);
    repeat (12) step();

    // 3: destination acks 10 cycles late; offers during the handshake ignored
    dly = 10;
    a_valid = 1'b1; a_bits = 15'h0ABC;
    step();
    a_bits = 15'h7FFF;
    nh = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (a_req) nh++;
      else break;
    end
    chk("t3_req_cycles", 64'(nh), 64'd13);
    chk("t3_ready_rel", {63'd0, a_ready}, 64'd0);
    chk("t3_data_frozen", {49'd0, a_data}, 64'h0ABC);
    step();
    a_valid = 1'b0;
    rt_a(n);
    chk("t3_returned", {63'd0, (n != 0)}, 64'd1);
    chk("t3_count", {56'd0, a_count}, 64'd6);
    chk("t3_data_final", {49'd0, a_data}, 64'h0ABC);
    repeat (12) step();
    dly = 0;

    // 4: reset in REQ while the destination keeps ack high
    a_valid = 1'b1; a_bits = 15'h0055;
    step();
    a_valid = 1'b0; ovr_en = 1'b1; ovr_val = 1'b1;
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("t4_req_before_rst", {63'd0, a_req}, 64'd1);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t4_req",   {63'd0, a_req},   64'd0);
    chk("t4_data",  {49'd0, a_data},  64'd0);
    chk("t4_busy",  {63'd0, a_busy},  64'd0);
    chk("t4_count", {56'd0, a_count}, 64'd0);
    repeat (3) step();
    @(negedge clk);
    chk("t4_ready_stale_ack", {63'd0, a_ready}, 64'd0);
    step();
    ovr_val = 1'b0;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (a_ready) begin n = i; break; end
    end
    chk("t4_ready_after_release", 64'(n), 64'd3);
    step();
    ovr_en = 1'b0;
    step();

    // 5 + 6: narrow counter wrap, 1-bit and 64-bit words, 3-stage sync
    xfer_bc(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 2'd1, "t5_x1");
    xfer_bc(1'b0, 64'hAAAA_AAAA_AAAA_AAAA, 2'd2, "t5_x2");
    xfer_bc(1'b1, 64'h5555_5555_5555_5555, 2'd3, "t5_x3");
    xfer_bc(1'b0, 64'h0000_0000_0000_0000, 2'd0, "t5_x4");
    xfer_bc(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 2'd1, "t5_x5");
    chk("t6_c_count", {56'd0, c_count}, 64'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
